debounce_bank: RTL

- Parametrised N-channel push-button conditioner. Each raw button/switch input is synchronised, debounced against a fixed stable-time threshold, and reported as a level plus one-cycle press and release pulses.
- Optional hold-to-repeat pulse train for held buttons, used by UI/menu logic.
- Sits between board pins and all control FSMs. Replaces per-button ad-hoc debounce instances with one bank.

---
 rtl/debounce_pkg.sv | 30 +++
 rtl/debounce_chan.sv | 105 ++++++++++
 rtl/debounce_bank.sv | 43 ++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the push-button debounce bank.
// Default timings assume the 100 MHz board clock.
package debounce_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    localparam int unsigned CLK_HZ            = 100_000_000;
    localparam int unsigned DEF_STABLE_CYCLES = CLK_HZ / 100;  // 10 ms
    localparam int unsigned DEF_HOLD_CYCLES   = CLK_HZ / 2;    // 500 ms
    localparam int unsigned DEF_REPEAT_CYCLES = CLK_HZ / 10;   // 100 ms

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Width of a counter that must hold values 0..max_count.
    function automatic int unsigned cnt_w(input int unsigned max_count);
        return max_u(1, clog2(max_count + 1));
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// Single-channel button conditioner: 2-flop synchroniser, stability counter,
// registered press/release pulses and optional hold-to-repeat pulse train.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_state,
    output logic btn_down,
    output logic btn_up,
    output logic btn_repeat
);

    localparam int unsigned     DB_W   = cnt_w(STABLE_CYCLES);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
        $error("debounce_chan: cycle counts must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_state;
    logic                   r_down;
    logic                   r_up;
    logic                   w_s;
    logic                   w_toggle;
    logic                   w_rise;
    logic                   w_fall;

    assign w_s      = r_sync[SYNC_STAGES-1];
    assign w_toggle = (w_s != r_state) && (r_cnt == DB_MAX);
    assign w_rise   = w_toggle && !r_state;
    assign w_fall   = w_toggle && r_state;

    // Polarity is corrected before the synchroniser so reset means "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_state <= 1'b0;
            r_down  <= 1'b0;
            r_up    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn ^ ACTIVE_LOW};
            if (w_s == r_state) begin
                r_cnt <= '0;
            end else if (w_toggle) begin
                r_cnt   <= '0;
                r_state <= ~r_state;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_down <= w_rise;
            r_up   <= w_fall;
        end
    end

    assign btn_state = r_state;
    assign btn_down  = r_down;
    assign btn_up    = r_up;

    if (REPEAT_EN) begin : g_rep
        localparam int unsigned     HC_W     = cnt_w(max_u(HOLD_CYCLES, REPEAT_CYCLES));
        localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_CYCLES - 1);
        localparam logic [HC_W-1:0] REP_MAX  = HC_W'(REPEAT_CYCLES - 1);

        logic [HC_W-1:0] r_hc;
        logic            r_first;
        logic            r_rep;
        logic [HC_W-1:0] w_target;
        logic            w_fire;

        // hc is 0 in the btn_down cycle; a pending release suppresses the pulse.
        assign w_target = r_first ? HOLD_MAX : REP_MAX;
        assign w_fire   = r_state && !w_fall && (r_hc == w_target);

        always_ff @(posedge clk) begin
            if (rst || !r_state) begin
                r_hc    <= '0;
                r_first <= 1'b1;
                r_rep   <= 1'b0;
            end else if (w_fire) begin
                r_hc    <= '0;
                r_first <= 1'b0;
                r_rep   <= 1'b1;
            end else begin
                r_hc  <= r_hc + 1'b1;
                r_rep <= 1'b0;
            end
        end

        assign btn_repeat = r_rep;
    end else begin : g_no_rep
        assign btn_repeat = 1'b0;
    end

endmodule

// File: rtl/debounce_bank.sv
// N-channel push-button conditioner built from independent debounce_chan slices.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter bit          ACTIVE_LOW    = 1'b0,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] btn,
    output logic [NUM_CH-1:0] btn_state,
    output logic [NUM_CH-1:0] btn_down,
    output logic [NUM_CH-1:0] btn_up,
    output logic [NUM_CH-1:0] btn_repeat
);

    if (NUM_CH < 1) begin : g_bad_param
        $error("debounce_bank: NUM_CH must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_chan #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW),
            .REPEAT_EN    (REPEAT_EN),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .btn       (btn[i]),
            .btn_state (btn_state[i]),
            .btn_down  (btn_down[i]),
            .btn_up    (btn_up[i]),
            .btn_repeat(btn_repeat[i])
        );
    end

endmodule
